// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpu_pkg
// Description : Shared definitions for the FPU and its front-end arbiter:
//               function codes, state encodings and the grant helper.
// Revision    : 1.0 - initial release
// ============================================================================
package fpu_pkg;

  // Function codes understood by the FPU. Any other code is forwarded as-is
  // and the FPU falls back to the plain product.
  localparam logic [2:0] FUNC_XFSQ = 3'd1;
  localparam logic [2:0] FUNC_DSQA = 3'd2;

  // Arbiter state machine.
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_RESP  = 2'd2
  } arb_state_t;

  // FPU state machine (used by the FPU core).
  typedef enum logic [1:0] {
    FPU_IDLE = 2'd0,
    FPU_BUSY = 2'd1,
    FPU_DONE = 2'd2
  } fpu_state_t;

  // Pick a grantee among two requesters. Only meaningful when req != 0.
  // With both requesting: round-robin favours the one not granted last,
  // fixed priority always picks requester 0.
  function automatic logic arb_pick(input logic [1:0] req,
                                    input logic       last,
                                    input logic       rr);
    logic sel;
    if (req == 2'b11) begin
      sel = rr ? ~last : 1'b0;
    end else begin
      sel = req[1];
    end
    return sel;
  endfunction

endpackage : fpu_pkg
`default_nettype wire

// File: rtl/fpu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fpu_arbiter
// Description : Two-requester front end for a single shared FPU. Grants one
//               requester, latches its function and operands, holds fpu_cs
//               until the FPU completes, then presents the result back to the
//               owner until it drops its request.
// Ports       : clk, rst_n            - clock, async active-low reset
//               req_cs[1:0]           - per-requester request level
//               req_func[5:0]         - {r1,r0} 3-bit function codes
//               req_rs1/rs2/rdr[63:0] - {r1,r0} single-precision operands
//               req_ready[1:0]        - per-requester result valid
//               req_rdw[63:0]         - {r1,r0} results (owner slice only)
//               fpu_cs, fpu_func, fpu_rs1, fpu_rs2, fpu_rdr - FPU request
//               fpu_ready, fpu_rdw    - FPU completion and result
//               busy                  - arbiter not idle
//               owner                 - index of current grantee
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_arbiter
  import fpu_pkg::*;
#(
  parameter int RR = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_cs,
  input  logic [5:0]  req_func,
  input  logic [63:0] req_rs1,
  input  logic [63:0] req_rs2,
  input  logic [63:0] req_rdr,
  output logic [1:0]  req_ready,
  output logic [63:0] req_rdw,
  output logic        fpu_cs,
  output logic [2:0]  fpu_func,
  output logic [31:0] fpu_rs1,
  output logic [31:0] fpu_rs2,
  output logic [31:0] fpu_rdr,
  input  logic        fpu_ready,
  input  logic [31:0] fpu_rdw,
  output logic        busy,
  output logic        owner
);

  localparam logic c_rr_en = (RR != 0);

  arb_state_t  r_state;
  logic        r_owner;
  logic        r_last;      // last grantee; reset value 1 favours requester 0
  logic        r_abandon;   // owner dropped its request during ISSUE
  logic        r_fpu_cs;
  logic        r_busy;
  logic [2:0]  r_func;
  logic [31:0] r_rs1;
  logic [31:0] r_rs2;
  logic [31:0] r_rdr;
  logic [31:0] r_result;
  logic [1:0]  r_ready;
  logic [63:0] r_rdw;

  logic        w_grant;
  logic        w_owner_req;

  assign w_grant     = arb_pick(req_cs, r_last, c_rr_en);
  assign w_owner_req = r_owner ? req_cs[1] : req_cs[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ARB_IDLE;
      r_owner   <= 1'b0;
      r_last    <= 1'b1;
      r_abandon <= 1'b0;
      r_fpu_cs  <= 1'b0;
      r_busy    <= 1'b0;
      r_func    <= 3'd0;
      r_rs1     <= 32'd0;
      r_rs2     <= 32'd0;
      r_rdr     <= 32'd0;
      r_result  <= 32'd0;
      r_ready   <= 2'b00;
      r_rdw     <= 64'd0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (|req_cs) begin
            r_owner   <= w_grant;
            r_last    <= w_grant;
            r_abandon <= 1'b0;
            r_func    <= w_grant ? req_func[5:3]  : req_func[2:0];
            r_rs1     <= w_grant ? req_rs1[63:32] : req_rs1[31:0];
            r_rs2     <= w_grant ? req_rs2[63:32] : req_rs2[31:0];
            r_rdr     <= w_grant ? req_rdr[63:32] : req_rdr[31:0];
            r_fpu_cs  <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= ARB_ISSUE;
          end
        end

        ARB_ISSUE: begin
          if (fpu_ready) begin
            // Dropping cs here means the FPU sees cs=0 on its next idle
            // cycle and does not start a second operation.
            r_fpu_cs <= 1'b0;
            r_result <= fpu_rdw;
            if (r_abandon || !w_owner_req) begin
              // The FPU cannot abort, so the result is simply discarded.
              r_busy  <= 1'b0;
              r_state <= ARB_IDLE;
            end else begin
              r_ready <= r_owner ? 2'b10 : 2'b01;
              r_rdw   <= r_owner ? {fpu_rdw, 32'd0} : {32'd0, fpu_rdw};
              r_state <= ARB_RESP;
            end
          end else if (!w_owner_req) begin
            r_abandon <= 1'b1;
          end
        end

        ARB_RESP: begin
          // No grant on the exit edge: a waiting requester is picked up
          // from IDLE on the following cycle.
          if (!w_owner_req) begin
            r_ready <= 2'b00;
            r_rdw   <= 64'd0;
            r_busy  <= 1'b0;
            r_state <= ARB_IDLE;
          end
        end

        default: begin
          r_fpu_cs <= 1'b0;
          r_busy   <= 1'b0;
          r_ready  <= 2'b00;
          r_rdw    <= 64'd0;
          r_state  <= ARB_IDLE;
        end
      endcase
    end
  end

  assign fpu_cs    = r_fpu_cs;
  assign fpu_func  = r_func;
  assign fpu_rs1   = r_rs1;
  assign fpu_rs2   = r_rs2;
  assign fpu_rdr   = r_rdr;
  assign req_ready = r_ready;
  assign req_rdw   = r_rdw;
  assign busy      = r_busy;
  assign owner     = r_owner;

endmodule : fpu_arbiter
`default_nettype wire

// File: tb/tb_fpu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpu_arbiter
// Description : Self-checking bench for fpu_arbiter. Two arbiters are built,
//               one round-robin and one fixed priority, each with a small
//               behavioural FPU model. Expected grants and results are queued
//               when stimulus is driven and compared when the DUT responds.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_arbiter;
  import fpu_pkg::*;

  localparam int FPU_LAT = 3;

  typedef struct {
    int          k;
    int          r;
    logic [31:0] v;
  } exp_t;

  logic        clk;
  logic        rst_n;

  logic [1:0]  req_cs    [2];
  logic [5:0]  req_func  [2];
  logic [63:0] req_rs1   [2];
  logic [63:0] req_rs2   [2];
  logic [63:0] req_rdr   [2];
  logic [1:0]  req_ready [2];
  logic [63:0] req_rdw   [2];
  logic        fpu_cs    [2];
  logic [2:0]  fpu_func  [2];
  logic [31:0] fpu_rs1   [2];
  logic [31:0] fpu_rs2   [2];
  logic [31:0] fpu_rdr   [2];
  logic        fpu_ready [2];
  logic [31:0] fpu_rdw   [2];
  logic        busy      [2];
  logic        owner     [2];
  int          fpu_starts[2];

  int n_checks = 0;
  int n_errors = 0;

  exp_t gq[$];     // expected grants
  exp_t exp_q[$];  // expected responses

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FPU result model: the spec vectors are given exact values by the
  // callers; other operands get a deterministic mix of all inputs.
  function automatic logic [31:0] fcalc(input logic [2:0] f, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] c);
    if (f == FUNC_DSQA && a == 32'h40400000 && b == 32'h3F800000 && c == 32'h3F800000)
      return 32'h40A00000;
    if (f == FUNC_XFSQ && a == 32'h40000000 && b == 32'h3F800000)
      return 32'h3F800000;
    return a ^ {b[15:0], b[31:16]} ^ (c + {29'd0, f});
  endfunction

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_dut
      fpu_arbiter #(.RR((g == 0) ? 1 : 0)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_cs    (req_cs[g]),
        .req_func  (req_func[g]),
        .req_rs1   (req_rs1[g]),
        .req_rs2   (req_rs2[g]),
        .req_rdr   (req_rdr[g]),
        .req_ready (req_ready[g]),
        .req_rdw   (req_rdw[g]),
        .fpu_cs    (fpu_cs[g]),
        .fpu_func  (fpu_func[g]),
        .fpu_rs1   (fpu_rs1[g]),
        .fpu_rs2   (fpu_rs2[g]),
        .fpu_rdr   (fpu_rdr[g]),
        .fpu_ready (fpu_ready[g]),
        .fpu_rdw   (fpu_rdw[g]),
        .busy      (busy[g]),
        .owner     (owner[g])
      );

      // Behavioural FPU: starts when it sees cs in IDLE, computes from the
      // operands it sees on the cycle it finishes, flags DONE for one cycle.
      fpu_state_t  st;
      int          cnt;
      int          starts;
      logic [31:0] res;
      always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          st <= FPU_IDLE; cnt <= 0; res <= 32'd0;
        end else begin
          case (st)
            FPU_IDLE: if (fpu_cs[g]) begin st <= FPU_BUSY; cnt <= FPU_LAT - 1; starts <= starts + 1; end
            FPU_BUSY: begin
              cnt <= cnt - 1;
              if (cnt == 1) begin
                st  <= FPU_DONE;
                res <= fcalc(fpu_func[g], fpu_rs1[g], fpu_rs2[g], fpu_rdr[g]);
              end
            end
            default: st <= FPU_IDLE;
          endcase
        end
      end
      initial starts = 0;
      assign fpu_ready[g]  = (st == FPU_DONE);
      assign fpu_rdw[g]    = (st == FPU_DONE) ? res : 32'd0;
      assign fpu_starts[g] = starts;
    end
  endgenerate

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  // Scoreboard monitor: compares grants and responses as they appear.
  logic prev_busy[2];
  logic [1:0] prev_rdy[2];
  int n_grants[2];
  exp_t mg, mr;
  initial begin
    prev_busy[0] = 0; prev_busy[1] = 0; prev_rdy[0] = 0; prev_rdy[1] = 0;
    n_grants[0] = 0; n_grants[1] = 0;
  end
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst_n && busy[k] && !prev_busy[k]) begin
        n_grants[k]++;
        if (gq.size() == 0) chk("grant_unexpected", 64'(k), 64'd99);
        else begin
          mg = gq.pop_front();
          chk("grant_dut", 64'(k), 64'(mg.k));
          chk("grant_owner", 64'(owner[k]), 64'(mg.r));
        end
      end
      if (req_ready[k] != 2'b00 && prev_rdy[k] == 2'b00) begin
        if (exp_q.size() == 0) chk("resp_unexpected", 64'(req_ready[k]), 64'd0);
        else begin
          mr = exp_q.pop_front();
          chk("resp_ready", {30'd0, 32'(k), req_ready[k]},
              {30'd0, 32'(mr.k), (mr.r == 1) ? 2'b10 : 2'b01});
          chk("resp_rdw", req_rdw[k], (mr.r == 1) ? {mr.v, 32'd0} : {32'd0, mr.v});
        end
      end
      prev_busy[k] = busy[k];
      prev_rdy[k]  = req_ready[k];
    end
  end

  task automatic set_op(input int k, input int r, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    req_func[k][r*3 +: 3]  = f;
    req_rs1[k][r*32 +: 32] = a;
    req_rs2[k][r*32 +: 32] = b;
    req_rdr[k][r*32 +: 32] = c;
  endtask

  task automatic op_vals(input int r, input int n, output logic [2:0] f,
                         output logic [31:0] a, output logic [31:0] b, output logic [31:0] c);
    f = (n % 3 == 0) ? FUNC_DSQA : ((n % 3 == 1) ? FUNC_XFSQ : 3'd5);
    a = 32'h1000_0000 + 32'(r << 8) + 32'(n);
    b = 32'h2345_6789 + 32'(n * 17) + 32'(r);
    c = 32'h0BAD_F00D ^ 32'(n << 4) ^ 32'(r << 20);
  endtask

  task automatic wait_sig(input int k, input int what, input int r, output bit ok);
    // what: 0 = req_ready[r], 1 = busy, 2 = fpu_ready, 3 = any req_ready
    ok = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if ((what == 0 && req_ready[k][r]) || (what == 1 && busy[k]) ||
          (what == 2 && fpu_ready[k]) || (what == 3 && req_ready[k] != 2'b00)) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("timeout", 64'(what), 64'd100);
  endtask

  task automatic run_single(input int k, input int r, input logic [2:0] f, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] c, input logic [31:0] expv);
    bit ok;
    gq.push_back('{k, r, 32'd0});
    exp_q.push_back('{k, r, expv});
    @(posedge clk); #1;
    set_op(k, r, f, a, b, c);
    req_cs[k][r] = 1'b1;
    wait_sig(k, 0, r, ok);
    @(posedge clk); #1;
    req_cs[k][r] = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  // Both requesters ask together and re-request until each has had n0/n1
  // services; ord gives the expected grant order.
  task automatic serve_both(input int k, input int n0, input int n1, input int ord[4]);
    int cnt[2];
    int served[2];
    int lim[2];
    int r;
    bit ok;
    logic [2:0] f;
    logic [31:0] a, b, c;
    cnt[0] = 0; cnt[1] = 0; served[0] = 0; served[1] = 0; lim[0] = n0; lim[1] = n1;
    for (int i = 0; i < n0 + n1; i++) begin
      op_vals(ord[i], cnt[ord[i]], f, a, b, c);
      gq.push_back('{k, ord[i], 32'd0});
      exp_q.push_back('{k, ord[i], fcalc(f, a, b, c)});
      cnt[ord[i]]++;
    end
    @(posedge clk); #1;
    for (int q = 0; q < 2; q++) begin
      op_vals(q, 0, f, a, b, c);
      set_op(k, q, f, a, b, c);
      req_cs[k][q] = 1'b1;
    end
    for (int i = 0; i < n0 + n1; i++) begin
      wait_sig(k, 3, 0, ok);
      if (!ok) break;
      r = req_ready[k][1] ? 1 : 0;
      served[r]++;
      @(posedge clk); #1;
      req_cs[k][r] = 1'b0;
      @(posedge clk); #1;
      if (served[r] < lim[r]) begin
        op_vals(r, served[r], f, a, b, c);
        set_op(k, r, f, a, b, c);
        req_cs[k][r] = 1'b1;
      end
    end
    req_cs[k] = 2'b00;
    repeat (3) @(posedge clk);
  endtask

  initial begin : main
    bit ok;
    logic [31:0] expv;
    for (int k = 0; k < 2; k++) begin
      req_cs[k] = 2'b00; req_func[k] = 6'd0;
      req_rs1[k] = 64'd0; req_rs2[k] = 64'd0; req_rdr[k] = 64'd0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    chk("rst_ready", 64'(req_ready[0]), 64'd0);
    chk("rst_rdw", req_rdw[0], 64'd0);
    chk("rst_busy", 64'(busy[0]), 64'd0);
    chk("rst_fpu_cs", 64'(fpu_cs[0]), 64'd0);
    chk("rst_owner", 64'(owner[0]), 64'd0);

    // Single request, DSQA (3-1)^2+1 = 5.0
    run_single(0, 0, FUNC_DSQA, 32'h40400000, 32'h3F800000, 32'h3F800000, 32'h40A00000);
    // Single request on r1 with an unrecognised function code
    run_single(0, 1, 3'd6, 32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F,
               fcalc(3'd6, 32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F));

    // Round-robin: last grant was r1, so order is r0,r1,r0,r1
    serve_both(0, 2, 2, '{0, 1, 0, 1});

    // Operand change after grant: result uses latched operands
    expv = fcalc(FUNC_XFSQ, 32'h41200000, 32'h40A00000, 32'h3F000000);
    gq.push_back('{0, 0, 32'd0});
    exp_q.push_back('{0, 0, expv});
    @(posedge clk); #1;
    set_op(0, 0, FUNC_XFSQ, 32'h41200000, 32'h40A00000, 32'h3F000000);
    req_cs[0][0] = 1'b1;
    wait_sig(0, 1, 0, ok);
    @(posedge clk); #1;
    set_op(0, 0, FUNC_DSQA, 32'hDEADBEEF, 32'hCAFEBABE, 32'h55AA55AA);
    wait_sig(0, 0, 0, ok);
    @(posedge clk); #1;
    req_cs[0][0] = 1'b0;
    repeat (2) @(posedge clk);

    // Abandon: r1 drops cs during ISSUE
    gq.push_back('{0, 1, 32'd0});
    @(posedge clk); #1;
    set_op(0, 1, FUNC_DSQA, 32'h3F800000, 32'h40000000, 32'h40400000);
    req_cs[0][1] = 1'b1;
    wait_sig(0, 1, 0, ok);
    @(posedge clk); #1;
    req_cs[0][1] = 1'b0;
    wait_sig(0, 2, 0, ok);
    @(negedge clk);
    chk("abandon_busy", 64'(busy[0]), 64'd0);
    chk("abandon_ready", 64'(req_ready[0]), 64'd0);
    chk("abandon_fpu_cs", 64'(fpu_cs[0]), 64'd0);
    run_single(0, 0, 3'd3, 32'h00000011, 32'h00000022, 32'h00000033,
               fcalc(3'd3, 32'h00000011, 32'h00000022, 32'h00000033));

    // Reset in the middle of ISSUE
    gq.push_back('{0, 1, 32'd0});
    @(posedge clk); #1;
    set_op(0, 1, FUNC_XFSQ, 32'h40800000, 32'h3F800000, 32'd0);
    req_cs[0][1] = 1'b1;
    wait_sig(0, 1, 0, ok);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_fpu_cs", 64'(fpu_cs[0]), 64'd0);
    chk("midrst_busy", 64'(busy[0]), 64'd0);
    chk("midrst_owner", 64'(owner[0]), 64'd0);
    chk("midrst_ready", 64'(req_ready[0]), 64'd0);
    chk("midrst_rdw", req_rdw[0], 64'd0);
    chk("midrst_fpu_rs1", 64'(fpu_rs1[0]), 64'd0);
    req_cs[0] = 2'b00;
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_single(0, 0, FUNC_XFSQ, 32'h40000000, 32'h3F800000, 32'h00000000, 32'h3F800000);

    // Fixed priority: r0 wins while it keeps requesting
    serve_both(1, 3, 1, '{0, 0, 0, 1});

    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("grants_left", 64'(gq.size()), 64'd0);
    chk("resps_left", 64'(exp_q.size()), 64'd0);
    chk("fpu_starts_rr", 64'(fpu_starts[0]), 64'(n_grants[0]));
    chk("fpu_starts_fp", 64'(fpu_starts[1]), 64'(n_grants[1]));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule : tb_fpu_arbiter
`default_nettype wire
